// File: rtl/io_pad_pkg.sv
// Shared types and helpers for the pad-ring ownership arbiters.
package io_pad_pkg;

   typedef enum logic [1:0] {IDLE, TURN, OWN} state_t;

   localparam int unsigned TCNT_W = 4;
   localparam int unsigned HCNT_W = 16;
   localparam int unsigned RR_MAX = 8;
   localparam int unsigned RR_IW  = 3;

   typedef struct packed {
      logic             found;
      logic [RR_IW-1:0] idx;
   } rr_res_t;

   // First set request at or after ptr, wrapping at n requesters.
   function automatic rr_res_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input logic [RR_IW-1:0]  ptr,
                                       input int unsigned       n);
      rr_res_t     res;
      int unsigned k;
      res = '0;
      for (int unsigned i = 0; i < RR_MAX; i++) begin
         k = 32'(ptr) + i;
         if (k >= n) k = k - n;
         if ((i < n) && !res.found && req[RR_IW'(k)]) begin
            res.found = 1'b1;
            res.idx   = RR_IW'(k);
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/io_pad_rr_pick.sv
// Combinational round-robin selector shared by the pad-ring arbiters.
module io_pad_rr_pick
   import io_pad_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
   output logic                       found_c_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_c_o
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   rr_res_t res;

   always_comb begin
      res       = rr_pick(RR_MAX'(req_i), RR_IW'(ptr_i), NUM_REQ);
      found_c_o = res.found;
      idx_c_o   = IW'(res.idx);
   end

endmodule

// File: rtl/io_pad_arb.sv
// Round-robin owner arbiter for a shared tri-state pad bank, with an
// all-enables-low turnaround gap between owners.
module io_pad_arb
   import io_pad_pkg::*;
#(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned PAD_W    = 8,
   parameter int unsigned TURN_CYC = 2,
   parameter int unsigned MAX_HOLD = 0
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_REQ-1:0]       req_i,
   output logic [NUM_REQ-1:0]       gnt_o,
   input  logic [NUM_REQ*PAD_W-1:0] req_c2p_i,
   input  logic [NUM_REQ*PAD_W-1:0] req_c2p_en_i,
   output logic [PAD_W-1:0]         req_p2c_o,
   output logic [PAD_W-1:0]         pad_c2p_o,
   output logic [PAD_W-1:0]         pad_c2p_en_o,
   input  logic [PAD_W-1:0]         pad_p2c_i,
   output logic                     busy_o
);

   localparam int unsigned IW = $clog2(NUM_REQ);

   state_t              state_q, state_d;
   logic [IW-1:0]       owner_q, owner_d;
   logic [IW-1:0]       rr_q, rr_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
   logic [NUM_REQ-1:0]  gnt_q;
   logic [PAD_W-1:0]    c2p_q, en_q, p2c_q;
   logic                busy_q;

   logic                pick_found;
   logic [IW-1:0]       pick_idx;
   logic [NUM_REQ-1:0]  owner_oh, owner_oh_d;
   logic                others, own_req, hold_exp;

   io_pad_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i    (req_i),
      .ptr_i    (rr_q),
      .found_c_o(pick_found),
      .idx_c_o  (pick_idx)
   );

   // Next-state: arbitration, turnaround and hold counters.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_d     = rr_q;
      tcnt_d   = tcnt_q;
      hcnt_d   = hcnt_q;
      owner_oh = NUM_REQ'(1) << owner_q;
      others   = |(req_i & ~owner_oh);
      own_req  = req_i[owner_q];
      hold_exp = (MAX_HOLD != 0) && (hcnt_q >= HCNT_W'(MAX_HOLD - 1));
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = TURN;
               owner_d = pick_idx;
               tcnt_d  = '0;
            end
         end
         TURN: begin
            if (tcnt_q == TCNT_W'(TURN_CYC - 1)) begin
               state_d = OWN;
               hcnt_d  = '0;
               rr_d    = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         OWN: begin
            if (hcnt_q != '1) hcnt_d = hcnt_q + HCNT_W'(1);
            // The departing owner is last in search order, so pick_idx is another requester.
            if ((!own_req || hold_exp) && others) begin
               state_d = TURN;
               owner_d = pick_idx;
               tcnt_d  = '0;
            end else if (!own_req) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      owner_oh_d = NUM_REQ'(1) << owner_d;
   end

   // State and registered pad/grant outputs; reset clears enables immediately.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_q    <= '0;
         tcnt_q  <= '0;
         hcnt_q  <= '0;
         gnt_q   <= '0;
         c2p_q   <= '0;
         en_q    <= '0;
         p2c_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         tcnt_q  <= tcnt_d;
         hcnt_q  <= hcnt_d;
         busy_q  <= (state_d != IDLE);
         if (state_d == OWN) begin
            gnt_q <= owner_oh_d;
            c2p_q <= req_c2p_i[int'(owner_d)*PAD_W +: PAD_W];
            en_q  <= req_c2p_en_i[int'(owner_d)*PAD_W +: PAD_W];
            p2c_q <= pad_p2c_i;
         end else begin
            gnt_q <= '0;
            c2p_q <= '0;
            en_q  <= '0;
            p2c_q <= '0;
         end
      end
   end

   assign gnt_o        = gnt_q;
   assign pad_c2p_o    = c2p_q;
   assign pad_c2p_en_o = en_q;
   assign req_p2c_o    = p2c_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_io_pad_arb.sv
// Self-checking bench for io_pad_arb: directed scenarios plus random traffic
// compared every cycle against a turn-taking reference model.
module tb_io_pad_arb;

   localparam int NR = 4;
   localparam int PW = 8;
   localparam int TC = 2;
   localparam int MH = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [NR-1:0]  req;
   logic [NR-1:0]  gnt;
   logic [NR*PW-1:0] c2p, en;
   logic [PW-1:0]  p2c_o, pad_c2p, pad_en, pad_p2c;
   logic           busy;

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the pads, who waits, how much gap/hold is left.
   int m_own, m_cand, m_gap, m_hold, m_ptr;
   logic [NR-1:0] e_gnt;
   logic          e_busy;
   logic [PW-1:0] e_c2p, e_en, e_p2c;

   always #5 clk = ~clk;

   io_pad_arb #(.NUM_REQ(NR), .PAD_W(PW), .TURN_CYC(TC), .MAX_HOLD(MH)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .gnt_o       (gnt),
      .req_c2p_i   (c2p),
      .req_c2p_en_i(en),
      .req_p2c_o   (p2c_o),
      .pad_c2p_o   (pad_c2p),
      .pad_c2p_en_o(pad_en),
      .pad_p2c_i   (pad_p2c),
      .busy_o      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int first_from(input logic [NR-1:0] r, input int ptr);
      for (int i = 0; i < NR; i++)
         if (r[(ptr + i) % NR]) return (ptr + i) % NR;
      return -1;
   endfunction

   task automatic model_reset();
      m_own = -1; m_cand = -1; m_gap = 0; m_hold = 0; m_ptr = 0;
      e_gnt = '0; e_busy = 1'b0; e_c2p = '0; e_en = '0; e_p2c = '0;
   endtask

   // Advance the model by one clock using the inputs present before the edge.
   task automatic model_step();
      logic [NR-1:0] oth;
      if (m_own >= 0) begin
         oth = req & ~(NR'(1) << m_own);
         if ((!req[m_own] || m_hold >= MH) && oth != 0) begin
            m_cand = first_from(oth, m_ptr);
            m_own  = -1;
            m_gap  = TC;
         end else if (!req[m_own]) begin
            m_own = -1;
         end else begin
            m_hold++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) begin
            m_own  = m_cand;
            m_ptr  = (m_cand + 1) % NR;
            m_hold = 1;
         end
      end else begin
         m_cand = first_from(req, m_ptr);
         if (m_cand >= 0) m_gap = TC;
      end
      e_busy = (m_own >= 0) || (m_gap > 0);
      if (m_own >= 0) begin
         e_gnt = NR'(1) << m_own;
         e_c2p = c2p[m_own*PW +: PW];
         e_en  = en[m_own*PW +: PW];
         e_p2c = pad_p2c;
      end else begin
         e_gnt = '0; e_c2p = '0; e_en = '0; e_p2c = '0;
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      chk("gnt",  32'(gnt),     32'(e_gnt));
      chk("busy", 32'(busy),    32'(e_busy));
      chk("en",   32'(pad_en),  32'(e_en));
      chk("c2p",  32'(pad_c2p), 32'(e_c2p));
      chk("p2c",  32'(p2c_o),   32'(e_p2c));
   endtask

   task automatic wait_gnt(input logic [NR-1:0] target, input int budget);
      int n = 0;
      while (gnt !== target && n < budget) begin
         cyc();
         n++;
      end
      chk("wait_gnt_timeout", 32'(gnt), 32'(target));
   endtask

   initial begin
      int            seq[$];
      int            exp_seq[5] = '{1, 2, 4, 8, 1};
      logic [NR-1:0] last_g;
      int            gap_n;

      rst = 1'b1; req = '0; c2p = '0; en = '0; pad_p2c = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_gnt",  32'(gnt),    0);
      chk("rst_busy", 32'(busy),   0);
      chk("rst_en",   32'(pad_en), 0);
      chk("rst_p2c",  32'(p2c_o),  0);
      rst = 1'b0;
      model_reset();
      repeat (3) cyc();

      // Single requester with requester 3 driving all-ones but not requesting.
      c2p = {8'hFF, 8'h00, 8'h00, 8'hA5};
      en  = {8'hFF, 8'h00, 8'h00, 8'h3C};
      pad_p2c = 8'h5A;
      req = 4'b0001;
      cyc();
      chk("lat_busy1", 32'(busy), 1);
      chk("lat_en1",   32'(pad_en), 0);
      cyc();
      chk("lat_gnt2",  32'(gnt), 0);
      cyc();
      chk("lat_gnt3",  32'(gnt), 4'b0001);
      chk("iso_en",    32'(pad_en), 8'h3C);
      chk("own_p2c",   32'(p2c_o), 8'h5A);
      en[7:0] = 8'hF0;
      cyc();
      chk("en_follow", 32'(pad_en), 8'hF0);

      // Asynchronous reset between edges while owning.
      #3 rst = 1'b1;
      #1;
      chk("arst_en",  32'(pad_en), 0);
      chk("arst_gnt", 32'(gnt), 0);
      chk("arst_c2p", 32'(pad_c2p), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      // Rotation under forced release with everyone requesting.
      req = 4'b1111;
      last_g = '0;
      for (int i = 0; i < 32; i++) begin
         cyc();
         if (gnt != 0 && gnt != last_g) seq.push_back(int'(gnt));
         last_g = gnt;
      end
      chk("rot_count", 32'(seq.size() >= 5), 1);
      for (int i = 0; i < 5; i++)
         if (i < seq.size()) chk("rot_seq", 32'(seq[i]), 32'(exp_seq[i]));

      // Handover from requester 1 to waiting requester 2.
      c2p = {8'h44, 8'h33, 8'h22, 8'h11};
      en  = {8'hFF, 8'h22, 8'h11, 8'h00};
      req = 4'b0110;
      wait_gnt(4'b0010, 40);
      req = 4'b0100;
      gap_n = 0;
      while (gnt !== 4'b0100 && gap_n < 10) begin
         cyc();
         if (gnt !== 4'b0100) begin
            gap_n++;
            chk("gap_en", 32'(pad_en), 0);
         end
      end
      chk("gap_len",  32'(gap_n), TC);
      chk("ho_en",    32'(pad_en), 8'h22);

      // Latched winner drops its request during turnaround.
      req = '0;
      repeat (3) cyc();
      chk("idle_busy", 32'(busy), 0);
      req = 4'b0100;
      cyc();
      chk("tdrop_busy", 32'(busy), 1);
      req = '0;
      cyc();
      cyc();
      chk("tdrop_gnt", 32'(gnt), 4'b0100);
      cyc();
      chk("tdrop_rel",  32'(gnt), 0);
      chk("tdrop_idle", 32'(busy), 0);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         for (int k = 0; k < NR; k++)
            if ($urandom_range(0, 7) == 0) req[k] = ~req[k];
         c2p = $urandom;
         en  = $urandom;
         pad_p2c = PW'($urandom);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
